// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, the
// post-reset hold length and width helpers.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_LOCK = 3'd4
  } state_e;

  // One UART frame is at most 11 bit periods (start, 8 data, parity, stop).
  localparam int unsigned INIT_FRAME_BITS = 11;

  function automatic int unsigned init_hold(input int unsigned cpb);
    return INIT_FRAME_BITS * cpb;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo the number of requesters.
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         hit,
  output logic [W-1:0] idx
);

  int         cand_s;
  logic [W-1:0] cand_idx_s;

  // Scan candidates in priority order starting from the pointer.
  always_comb begin
    hit        = 1'b0;
    idx        = '0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand_s     = (int'(ptr) + k) % int'(N);
      cand_idx_s = W'(cand_s);
      if (!hit && req[cand_idx_s]) begin
        hit = 1'b1;
        idx = cand_idx_s;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto one UART transmitter, keeping multi-byte
// packets together and releasing a stalled packet lock after a timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned clocks_per_bit = 1,
  parameter int unsigned num_requesters = 4,
  parameter int unsigned lock_timeout   = 1024
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [num_requesters-1:0]           req_valid,
  input  logic [8*num_requesters-1:0]         req_byte,
  input  logic [num_requesters-1:0]           req_last,
  output logic [num_requesters-1:0]           req_ready,
  output logic                                uart_send,
  output logic [7:0]                          uart_byte,
  input  logic                                uart_done,
  output logic [idx_width(num_requesters)-1:0] grant,
  output logic                                busy,
  output logic                                timeout_event
);

  localparam int unsigned NR        = num_requesters;
  localparam int unsigned W         = idx_width(NR);
  localparam int unsigned INIT_HOLD = init_hold(clocks_per_bit);
  localparam int unsigned CNT_W     = idx_width(max_u(INIT_HOLD, lock_timeout));

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [W-1:0]    grant_q, grant_d;
  logic [7:0]      byte_q, byte_d;
  logic            last_q, last_d;
  logic            send_q, send_d;
  logic [NR-1:0]   ready_q, ready_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;

  logic            sel_hit_s;
  logic [W-1:0]    sel_idx_s;
  logic [W-1:0]    ptr_inc_s;

  rr_select #(.N(NR), .W(W)) u_rr_select (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .hit (sel_hit_s),
    .idx (sel_idx_s)
  );

  assign ptr_inc_s = (grant_q == W'(NR - 1)) ? '0 : grant_q + W'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    byte_d    = byte_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(INIT_HOLD - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (sel_hit_s) begin
          grant_d = sel_idx_s;
          byte_d  = req_byte[{sel_idx_s, 3'b000} +: 8];
          last_d  = req_last[sel_idx_s];
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (uart_done) begin
          if (last_q) begin
            rr_ptr_d = ptr_inc_s;
            state_d  = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_LOCK;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_LOCK: begin
        // A byte on the terminal-count clock still wins over the timeout.
        if (req_valid[grant_q]) begin
          byte_d  = req_byte[{grant_q, 3'b000} +: 8];
          last_d  = req_last[grant_q];
          state_d = ST_SEND;
        end else if (cnt_q == CNT_W'(lock_timeout - 1)) begin
          timeout_d = 1'b1;
          rr_ptr_d  = ptr_inc_s;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    send_d  = (state_d == ST_SEND);
    ready_d = (state_d == ST_SEND) ? (NR'(1) << grant_d) : '0;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      byte_q    <= 8'h00;
      last_q    <= 1'b0;
      send_q    <= 1'b0;
      ready_q   <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      send_q    <= send_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ready     = ready_q;
  assign uart_send     = send_q;
  assign uart_byte     = byte_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign timeout_event = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with 4 requesters, 4 clocks/bit and a
// 16-clock lock timeout; expected values are hand-computed constants.
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_byte;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        uart_send;
  logic [7:0]  uart_byte;
  logic        uart_done;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_event;

  int tests_run;
  int tests_failed;

  uart_tx_arbiter #(.clocks_per_bit(4), .num_requesters(4), .lock_timeout(16)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_byte(req_byte),
    .req_last(req_last), .req_ready(req_ready), .uart_send(uart_send),
    .uart_byte(uart_byte), .uart_done(uart_done), .grant(grant), .busy(busy),
    .timeout_event(timeout_event)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input int port, input logic [7:0] b, input logic last);
    req_byte[8*port +: 8] = b;
    req_last[port]        = last;
    req_valid[port]       = 1'b1;
  endtask

  task automatic wait_send(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!uart_send && n < 200);
    check_eq("send_seen", {31'b0, uart_send}, 32'd1);
  endtask

  // Hold the frame for a few clocks, confirming the byte is stable, then pulse done.
  task automatic finish_frame(input logic [7:0] exp_byte, input int hold);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (uart_byte !== exp_byte || uart_send !== 1'b0) ok = 1'b0;
    end
    check_eq("frame_stable", {31'b0, ok}, 32'd1);
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},    {31'b0, busy},          32'd1);
    check_eq({tag, "_send"},    {31'b0, uart_send},     32'd0);
    check_eq({tag, "_ready"},   {28'b0, req_ready},     32'd0);
    check_eq({tag, "_byte"},    {24'b0, uart_byte},     32'd0);
    check_eq({tag, "_grant"},   {30'b0, grant},         32'd0);
    check_eq({tag, "_timeout"}, {31'b0, timeout_event}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first_send;
    logic quiet;
    logic [1:0] exp_g [4];
    tests_run    = 0;
    tests_failed = 0;
    reset_n   = 1'b0;
    req_valid = 4'b0;
    req_byte  = 32'h0;
    req_last  = 4'b0;
    uart_done = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Power-up hold of 44 clocks, then the first byte from port 0.
    reset_n    = 1'b1;
    first_send = 0;
    for (int t = 1; t <= 100 && first_send == 0; t++) begin
      if (t == 10) offer(0, 8'h55, 1'b1);
      tick();
      if (uart_send) first_send = t;
    end
    check_eq("init_latency", first_send, 32'd45);
    check_eq("t1_byte",  {24'b0, uart_byte}, 32'h55);
    check_eq("t1_ready", {28'b0, req_ready}, 32'b0001);
    check_eq("t1_grant", {30'b0, grant},     32'd0);
    req_valid = 4'b0;
    tick();
    check_eq("t1_ready_pulse", {28'b0, req_ready}, 32'b0000);
    finish_frame(8'h55, 2);
    check_eq("t1_idle", {31'b0, busy}, 32'd0);

    // Strict rotation between continuously requesting ports 1 and 3.
    exp_g[0] = 2'd1; exp_g[1] = 2'd3; exp_g[2] = 2'd1; exp_g[3] = 2'd3;
    offer(1, 8'h11, 1'b1);
    offer(3, 8'h33, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_send(n);
      check_eq("rot_grant", {30'b0, grant}, {30'b0, exp_g[i]});
      check_eq("rot_byte", {24'b0, uart_byte}, (exp_g[i] == 2'd1) ? 32'h11 : 32'h33);
      check_eq("rot_ready", {28'b0, req_ready}, (exp_g[i] == 2'd1) ? 32'b0010 : 32'b1000);
      if (i == 3) req_valid = 4'b0;
      finish_frame((exp_g[i] == 2'd1) ? 8'h11 : 8'h33, 3);
    end

    // Two-byte packet from port 2 keeps the line while port 0 waits.
    offer(2, 8'hA1, 1'b0);
    wait_send(n);
    check_eq("pkt_g1", {30'b0, grant}, 32'd2);
    check_eq("pkt_b1", {24'b0, uart_byte}, 32'hA1);
    req_valid[2] = 1'b0;
    offer(0, 8'h0F, 1'b1);
    finish_frame(8'hA1, 3);
    repeat (3) tick();
    check_eq("lock_no_send", {31'b0, uart_send}, 32'd0);
    offer(2, 8'hA2, 1'b1);
    wait_send(n);
    check_eq("lock_latency", n, 32'd1);
    check_eq("pkt_g2", {30'b0, grant}, 32'd2);
    check_eq("pkt_b2", {24'b0, uart_byte}, 32'hA2);
    req_valid[2] = 1'b0;
    finish_frame(8'hA2, 2);
    wait_send(n);
    check_eq("pkt_then_p0", {30'b0, grant}, 32'd0);
    check_eq("pkt_p0_byte", {24'b0, uart_byte}, 32'h0F);
    req_valid[0] = 1'b0;
    finish_frame(8'h0F, 2);

    // Lock timeout: port 2 goes silent; ports 3 and 0 wait, 3 is next.
    offer(2, 8'hB1, 1'b0);
    wait_send(n);
    check_eq("to_grant", {30'b0, grant}, 32'd2);
    req_valid[2] = 1'b0;
    offer(3, 8'h3C, 1'b1);
    offer(0, 8'h0C, 1'b1);
    finish_frame(8'hB1, 2);
    first_send = 0;
    quiet      = 1'b1;
    for (int t = 1; t <= 40 && first_send == 0; t++) begin
      tick();
      if (uart_send) quiet = 1'b0;
      if (timeout_event) first_send = t;
    end
    check_eq("to_delay", first_send, 32'd16);
    check_eq("to_quiet", {31'b0, quiet}, 32'd1);
    wait_send(n);
    check_eq("to_pulse_once", {31'b0, timeout_event}, 32'd0);
    check_eq("to_next_grant", {30'b0, grant}, 32'd3);
    check_eq("to_next_latency", n, 32'd1);
    req_valid[3] = 1'b0;
    finish_frame(8'h3C, 2);
    wait_send(n);
    check_eq("to_then_p0", {30'b0, grant}, 32'd0);
    req_valid[0] = 1'b0;
    finish_frame(8'h0C, 2);

    // Byte arriving on the terminal-count clock beats the timeout.
    offer(2, 8'hC1, 1'b0);
    wait_send(n);
    check_eq("tc_grant", {30'b0, grant}, 32'd2);
    req_valid[2] = 1'b0;
    finish_frame(8'hC1, 2);
    quiet = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (timeout_event || uart_send) quiet = 1'b0;
    end
    check_eq("tc_quiet", {31'b0, quiet}, 32'd1);
    offer(2, 8'hC2, 1'b1);
    tick();
    check_eq("tc_send", {31'b0, uart_send}, 32'd1);
    check_eq("tc_no_timeout", {31'b0, timeout_event}, 32'd0);
    check_eq("tc_byte", {24'b0, uart_byte}, 32'hC2);
    req_valid[2] = 1'b0;
    finish_frame(8'hC2, 2);

    // Reset during WAIT, then a stray uart_done during the INIT hold.
    offer(1, 8'h77, 1'b1);
    wait_send(n);
    check_eq("rst_pre_grant", {30'b0, grant}, 32'd1);
    repeat (2) tick();
    reset_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    tick();
    reset_n    = 1'b1;
    first_send = 0;
    quiet      = 1'b1;
    for (int t = 1; t <= 100 && first_send == 0; t++) begin
      uart_done = (t == 5);
      tick();
      if (req_ready != 4'b0 && t < 45) quiet = 1'b0;
      if (uart_send) first_send = t;
    end
    uart_done = 1'b0;
    check_eq("rst_init_quiet", {31'b0, quiet}, 32'd1);
    check_eq("rst_latency", first_send, 32'd45);
    check_eq("rst_grant", {30'b0, grant}, 32'd1);
    check_eq("rst_byte", {24'b0, uart_byte}, 32'h77);
    req_valid = 4'b0;
    finish_frame(8'h77, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter clocks_per_bit, default 1, meaning UART bit period in clocks, used only for the post-reset hold.
REQ-002 SHALL have parameter num_requesters, default 4, meaning the number of requester ports (2..8).
REQ-003 SHALL have parameter lock_timeout, default 1024, meaning the number of idle clocks allowed inside a locked packet.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports are named clock and reset_n.
REQ-005 SHALL provide: clock  in  1  system clock.
REQ-006 SHALL provide: reset_n  in  1  async active-low reset.
REQ-007 SHALL provide: req_valid  in  num_requesters  per-requester byte-available flag.
REQ-008 SHALL provide: req_byte  in  8*num_requesters  byte for requester i on bits [8i+7:8i].
REQ-009 SHALL provide: req_last  in  num_requesters  marks the offered byte as the final byte of its packet.
REQ-010 SHALL provide: req_ready  out  num_requesters  one-clock accept pulse per requester.
REQ-011 SHALL provide: uart_send  out  1  start pulse to the uart transmitter.
REQ-012 SHALL provide: uart_byte  out  8  byte to the transmitter, held stable for the whole frame.
REQ-013 SHALL provide: uart_done  in  1  end-of-frame pulse from the transmitter.
REQ-014 SHALL provide: grant  out  clog2(num_requesters)  index of the current or last owner.
REQ-015 SHALL provide: busy  out  1  high in any state other than IDLE.
REQ-016 SHALL provide: timeout_event  out  1  one-clock pulse when a lock is dropped by timeout.

Function
REQ-017 SHALL implement states INIT, IDLE, SEND, WAIT, LOCK.
REQ-018 INIT: SHALL count 11*clocks_per_bit clocks, ignore requests and uart_done, then go to IDLE.
REQ-019 IDLE: on any req_valid, SHALL select the first set bit at or after rr_ptr, wrapping modulo num_requesters; latch req_byte, req_last and grant; go to SEND.
REQ-020 SEND: SHALL hold uart_send=1 and req_ready[grant]=1 for exactly this one clock, both registered; go to WAIT.
REQ-021 Latency: uart_send SHALL rise on the first clock after req_valid is sampled in IDLE or LOCK.
REQ-022 WAIT: uart_byte SHALL remain constant, because the transmitter reads it live during the frame; uart_done SHALL be ignored in every state except WAIT.
REQ-023 WAIT on uart_done: if the latched last=1, SHALL set rr_ptr=grant+1 (wrapping) and go to IDLE; else SHALL clear the lock counter and go to LOCK.
REQ-024 LOCK: SHALL serve only req_valid[grant]; when it is seen, latch and go to SEND; other requesters SHALL be ignored.
REQ-025 LOCK timeout: when the counter reaches lock_timeout-1 without req_valid[grant], SHALL pulse timeout_event, set rr_ptr=grant+1 and go to IDLE.
REQ-026 LOCK simultaneity: if req_valid[grant] and the counter terminal count occur on the same clock, the byte SHALL win and no timeout SHALL be raised.
REQ-027 Requesters SHALL hold req_valid, req_byte and req_last stable until they see req_ready; dropping req_valid earlier withdraws the offer with no side effects.
REQ-028 Fairness: consecutive packets from continuously-requesting ports SHALL be granted in strict rotation.

Reset
REQ-029 On reset_n low, SHALL immediately force: state INIT, rr_ptr 0, grant 0, uart_send 0, req_ready 0, uart_byte 0x00, timeout_event 0, busy 1, counters 0.
REQ-030 Reset mid-frame SHALL abandon the packet with no req_ready; the INIT hold covers a transmitter frame still in flight, since the transmitter has no reset.

Structure
REQ-031 A shared package SHALL hold the state encoding, INIT_HOLD (11*clocks_per_bit) and width helpers.
REQ-032 Round-robin selection SHALL be one combinational sub-module, rr_select (inputs: request vector and pointer; outputs: hit and index).

Verification (num_requesters=4, clocks_per_bit=4, lock_timeout=16)
REQ-033 Release reset, assert req_valid[0] with byte 0x55 and last=1 at clock 10 -> no uart_send before clock 44 after release; then one uart_send with uart_byte=0x55 and req_ready[0] in the same clock.
REQ-034 Ports 1 and 3 valid continuously with last=1 -> grants alternate 1,3,1,3; uart_byte is stable between each uart_send and its uart_done.
REQ-035 Port 2 sends 0xA1 (last=0), then 0xA2 (last=1) three clocks after done, while port 0 is valid -> port 2 is served twice, then port 0.
REQ-036 Port 2 sends with last=0 and then goes silent -> timeout_event pulses 16 clocks after LOCK entry, and the next grant goes to port 3 (or the next requesting port).
REQ-037 Assert reset_n low during WAIT -> all outputs at reset values at once; a uart_done arriving during INIT is ignored and no req_ready is issued.
REQ-038 req_valid[grant] on the timeout clock -> byte accepted, no timeout_event.
